mips_data_ram_harvard: RTL and testbench

Data-side memory responder for mips_cpu_harvard. It answers the CPU's data_address / data_read / data_write / byteenable / data_writedata accesses.
- Reads are combinational, so read data is valid in the same cycle, which the CPU's EXEC2 load path relies on.
- Writes commit on the clock edge, with per-byte lane enables.
- It keeps a sticky access-error flag and read/write counters for the testbench to check.
- It sits beside the CPU in the simulation top, opposite the instruction ROM.

---
 rtl/mips_data_ram_harvard.sv | 103 ++++++++++
 tb/tb_mips_data_ram_harvard.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mips_data_ram_harvard.sv
// Data-side RAM for mips_cpu_harvard: combinational reads, byte-lane writes on
// the clock edge, a sticky access-error flag and read/write access counters.
module mips_data_ram_harvard #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          DEPTH_WORDS = 1024,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        access_error,
  output logic [31:0] read_count,
  output logic [31:0] write_count
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // End of the window, one past the last byte, in 33 bits so it cannot wrap.
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic          access_error_q = 1'b0;
  logic          access_error_d;
  logic [31:0]   read_count_q = '0;
  logic [31:0]   read_count_d;
  logic [31:0]   write_count_q = '0;
  logic [31:0]   write_count_d;

  logic          in_range;
  logic [AW-1:0] word_idx;
  logic          rd_ok;
  logic          wr_ok;
  logic          err_now;

  // Start-of-time contents: zeros.
  initial begin
    for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] = '0;
  end

  // Strobe semantics: there is no handshake back-pressure. Exactly one of
  // data_read / data_write high with an in-window address is an accepted
  // access that completes in the cycle it is presented; every high cycle is
  // a separate access. Both strobes high, or a strobe with an out-of-window
  // address, is rejected (no write, zero read data) and flagged.
  // Address decode relative to the window base.
  always_comb begin
    in_range = ({1'b0, data_address} >= {1'b0, BASE_ADDR}) &&
               ({1'b0, data_address} < END_ADDR);
    word_idx = data_address[AW+1:2] - BASE_ADDR[AW+1:2];
    rd_ok    = data_read && !data_write && in_range;
    wr_ok    = data_write && !data_read && in_range;
    // A misaligned write still commits; it only raises the flag.
    err_now  = (data_read && data_write) ||
               ((data_read || data_write) && !in_range) ||
               (data_write && (data_address[1:0] != 2'b00));
  end

  // Zero-latency read port; the CPU extracts bytes/halfwords itself.
  always_comb begin
    data_readdata = 32'h0000_0000;
    if (rd_ok) data_readdata = mem_q[word_idx];
  end

  // Next-state for the flag and counters.
  always_comb begin
    access_error_d = access_error_q | err_now;
    read_count_d   = read_count_q;
    write_count_d  = write_count_q;
    if (rd_ok) read_count_d = read_count_q + 32'd1;
    if (wr_ok) write_count_d = write_count_q + 32'd1;
  end

  // Status registers; reset clears them but never touches the array.
  always_ff @(posedge clk) begin
    if (reset) begin
      access_error_q <= 1'b0;
      read_count_q   <= '0;
      write_count_q  <= '0;
    end else begin
      access_error_q <= access_error_d;
      read_count_q   <= read_count_d;
      write_count_q  <= write_count_d;
    end
  end

  // Byte-lane write commit; disabled lanes keep their contents.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) mem_q[word_idx][8*i +: 8] <= data_writedata[8*i +: 8];
      end
    end
  end

  assign access_error = access_error_q;
  assign read_count   = read_count_q;
  assign write_count  = write_count_q;

endmodule

// File: tb/tb_mips_data_ram_harvard.sv
// Bench for mips_data_ram_harvard: directed scenarios followed by random
// accesses, all checked against a word-array reference model.
module tb_mips_data_ram_harvard;

   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int          DEPTH = 1024;
   localparam longint      END_B = longint'(BASE) + 4 * DEPTH;
   localparam logic [31:0] LAST  = BASE + 4 * (DEPTH - 1);

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] data_address = '0;
   logic        data_read = 1'b0;
   logic        data_write = 1'b0;
   logic [3:0]  byteenable = '0;
   logic [31:0] data_writedata = '0;
   logic [31:0] data_readdata;
   logic        access_error;
   logic [31:0] read_count;
   logic [31:0] write_count;

   int num_checks = 0;
   int num_errors = 0;

   // Reference model state
   logic [31:0] model_mem [DEPTH];
   logic        model_err = 1'b0;
   logic [31:0] model_rc  = '0;
   logic [31:0] model_wc  = '0;
   logic [31:0] exp_q [$];

   mips_data_ram_harvard #(
      .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .INIT_FILE("")
   ) dut (
      .clk(clk), .reset(reset), .data_address(data_address),
      .data_read(data_read), .data_write(data_write), .byteenable(byteenable),
      .data_writedata(data_writedata), .data_readdata(data_readdata),
      .access_error(access_error), .read_count(read_count),
      .write_count(write_count)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      num_checks++;
      if (got !== exp) begin
         num_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic bit addr_in_window(input logic [31:0] a);
      return (longint'(a) >= longint'(BASE)) && (longint'(a) < END_B);
   endfunction

   function automatic int word_of(input logic [31:0] a);
      return int'((longint'(a) - longint'(BASE)) / 4);
   endfunction

   // One access cycle: inputs driven after the falling edge, read data checked
   // before the rising edge, registered status checked just after it.
   task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] wd, input logic rst);
      bit          inw;
      int          w;
      logic [31:0] word;
      data_read = rd; data_write = wr; data_address = a;
      byteenable = be; data_writedata = wd; reset = rst;
      inw = addr_in_window(a);
      w = inw ? word_of(a) : 0;
      #1;
      exp_q.push_back((rd && !wr && inw) ? model_mem[w] : 32'h0);
      check_eq("rdata", data_readdata, exp_q.pop_front());
      @(posedge clk);
      if (rst) begin
         model_err = 1'b0; model_rc = '0; model_wc = '0;
      end else if ((rd && wr) || ((rd || wr) && !inw)) begin
         model_err = 1'b1;
      end else begin
         if (rd) model_rc = model_rc + 1;
         if (wr) begin
            word = model_mem[w];
            for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = wd[8*i +: 8];
            model_mem[w] = word;
            model_wc = model_wc + 1;
            if (a[1:0] != 2'b00) model_err = 1'b1;
         end
      end
      #1;
      check_eq("access_error", {31'b0, access_error}, {31'b0, model_err});
      check_eq("read_count", read_count, model_rc);
      check_eq("write_count", write_count, model_wc);
      @(negedge clk);
      data_read = 1'b0; data_write = 1'b0; reset = 1'b0;
   endtask

   task automatic wr_word(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      do_access(1'b0, 1'b1, a, be, d, 1'b0);
   endtask

   task automatic rd_word(input logic [31:0] a);
      do_access(1'b1, 1'b0, a, 4'h0, 32'h0, 1'b0);
   endtask

   function automatic logic [31:0] pick_addr();
      int unsigned sel;
      logic [31:0] a;
      sel = $urandom_range(0, 19);
      if (sel < 14)       a = BASE + 32'(4 * $urandom_range(0, 7));
      else if (sel == 14) a = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
      else if (sel == 15) a = 32'h0000_0FFC;
      else if (sel == 16) a = BASE + 32'(4 * DEPTH);
      else if (sel == 17) a = LAST;
      else if (sel == 18) a = $urandom;
      else                a = 32'hFFFF_FFFC;
      return a;
   endfunction

   initial begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      @(negedge clk);
      // Power-up values before any reset
      check_eq("init_error", {31'b0, access_error}, 32'h0);
      check_eq("init_rc", read_count, 32'h0);
      check_eq("init_wc", write_count, 32'h0);

      // 1: reset, full write, readback
      do_access(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
      wr_word(32'h0000_1004, 4'hF, 32'hDEAD_BEEF);
      rd_word(32'h0000_1004);

      // 2: partial and zero-lane writes
      wr_word(32'h0000_1008, 4'hF, 32'h1122_3344);
      wr_word(32'h0000_1008, 4'b0101, 32'hAABB_CCDD);
      rd_word(32'h0000_1008);
      check_eq("partial_word", model_mem[2], 32'h11BB_33DD);
      wr_word(32'h0000_1008, 4'b0000, 32'hFFFF_FFFF);
      rd_word(32'h0000_1008);

      // 3: out-of-range read / write, then reset clears the flag
      rd_word(32'h0000_0FFC);
      wr_word(BASE + 32'(4 * DEPTH), 4'hF, 32'h0BAD_0BAD);
      rd_word(LAST);
      do_access(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);

      // 4: both strobes together
      wr_word(32'h0000_1000, 4'hF, 32'h0000_0077);
      do_access(1'b1, 1'b1, 32'h0000_1000, 4'hF, 32'h5555_5555, 1'b0);
      rd_word(32'h0000_1000);

      // 5: reset with a concurrent write; array survives reset
      wr_word(32'h0000_1010, 4'hF, 32'h1234_5678);
      do_access(1'b0, 1'b1, 32'h0000_1010, 4'hF, 32'hFFFF_FFFF, 1'b1);
      rd_word(32'h0000_1010);
      rd_word(32'h0000_1000);
      // read asserted during reset still returns data combinationally
      do_access(1'b1, 1'b0, 32'h0000_1010, 4'h0, 32'h0, 1'b1);

      // 6: last word, misaligned write, counter wrap
      wr_word(LAST, 4'hF, 32'h0F0E_0D0C);
      rd_word(LAST);
      wr_word(32'h0000_1002, 4'hF, 32'hCAFE_F00D);
      do_access(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
      rd_word(32'h0000_1000);
      dut.write_count_q = 32'hFFFF_FFFF;
      model_wc = 32'hFFFF_FFFF;
      wr_word(32'h0000_100C, 4'hF, 32'h0000_0001);
      check_eq("wc_wrapped", write_count, 32'h0);

      // Random accesses
      for (int n = 0; n < 400; n++) begin
         int unsigned kind;
         logic rd, wr, rst;
         kind = $urandom_range(0, 9);
         rd  = (kind < 4) || (kind == 8);
         wr  = (kind >= 4 && kind < 8) || (kind == 8);
         rst = ($urandom_range(0, 39) == 0);
         do_access(rd, wr, pick_addr(), 4'($urandom_range(0, 15)), $urandom, rst);
      end

      // Final sweep of the small working set
      for (int i = 0; i < 8; i++) rd_word(BASE + 32'(4 * i));

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
